// File: rtl/traffic_phase_scheduler.sv
// Timed Red -> Green -> Yellow sequencer feeding the traffic-light control unit.
// Optional macro TRAFFIC_PED_SHORTEN_EN: a pending pedestrian request cuts Green down to MIN_GREEN ticks.
module traffic_phase_scheduler #(
   parameter int CNT_W     = 8,
   parameter int PRESCALE  = 1000,
   parameter int MIN_GREEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] red_time,
   input  logic [CNT_W-1:0] green_time,
   input  logic [CNT_W-1:0] yellow_time,
   input  logic             ped_req,
   output logic [1:0]       sw_traffic_lights,
   output logic [CNT_W-1:0] phase_remaining,
   output logic             phase_done,
   output logic             ped_walk
);

   localparam logic [1:0]  ST_IDLE   = 2'b00;
   localparam logic [1:0]  ST_RED    = 2'b01;
   localparam logic [1:0]  ST_GREEN  = 2'b10;
   localparam logic [1:0]  ST_YELLOW = 2'b11;
   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   // A zero duration would otherwise stall or wrap the remaining-tick counter.
   function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] t);
      return (t == '0) ? CNT_W'(1) : t;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             done_q, done_d;
   logic             walk_q, walk_d;
   logic             pend_q, pend_d;
   logic [15:0]      presc_q, presc_d;
   logic             tick;
   logic             phase_change;
   logic [1:0]       next_state;
   logic [CNT_W-1:0] next_dur;

`ifdef TRAFFIC_PED_SHORTEN_EN
   localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
   logic             short_q, short_d;
`else
   logic [31:0]      min_green_unused;
   assign min_green_unused = MIN_GREEN;
`endif

   always_comb begin
      tick = (presc_q == PRESC_MAX);
      case (state_q)
         ST_RED: begin
            next_state = ST_GREEN;
            next_dur   = clamp_dur(green_time);
         end
         ST_GREEN: begin
            next_state = ST_YELLOW;
            next_dur   = clamp_dur(yellow_time);
         end
         default: begin
            next_state = ST_RED;
            next_dur   = clamp_dur(red_time);
         end
      endcase
      phase_change = enable && ((state_q == ST_IDLE) || (tick && (rem_q <= CNT_W'(1))));
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      walk_d  = walk_q;
      presc_d = presc_q;
      // Requests during an active walk are already being served.
      pend_d  = pend_q | (ped_req && !((state_q == ST_RED) && walk_q));
`ifdef TRAFFIC_PED_SHORTEN_EN
      short_d = short_q;
`endif
      if (enable) begin
         presc_d = tick ? 16'd0 : presc_q + 16'd1;
         if (phase_change) begin
            state_d = next_state;
            rem_d   = next_dur;
            presc_d = 16'd0;
            done_d  = 1'b1;
`ifdef TRAFFIC_PED_SHORTEN_EN
            short_d = 1'b0;
`endif
            if (next_state == ST_RED) begin
               walk_d = pend_q | ped_req;
               pend_d = 1'b0;
            end else begin
               walk_d = 1'b0;
            end
         end else begin
            if (tick) begin
               rem_d = rem_q - CNT_W'(1);
            end
`ifdef TRAFFIC_PED_SHORTEN_EN
            // Prescaler keeps running so the current tick is not restarted.
            if ((state_q == ST_GREEN) && pend_q && !short_q && (rem_q > MIN_G)) begin
               rem_d   = MIN_G;
               short_d = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         done_q  <= 1'b0;
         walk_q  <= 1'b0;
         pend_q  <= 1'b0;
         presc_q <= 16'd0;
`ifdef TRAFFIC_PED_SHORTEN_EN
         short_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         walk_q  <= walk_d;
         pend_q  <= pend_d;
         presc_q <= presc_d;
`ifdef TRAFFIC_PED_SHORTEN_EN
         short_q <= short_d;
`endif
      end
   end

   assign sw_traffic_lights = state_q;
   assign phase_remaining   = rem_q;
   assign phase_done        = done_q;
   assign ped_walk          = walk_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed phase-timing scenarios plus randomized traffic
// against an elapsed-cycle model of the phase sequence.
module tb_traffic_phase_scheduler;
   localparam int P    = 2;
   localparam int MING = 2;
`ifdef TRAFFIC_PED_SHORTEN_EN
   localparam int PED_GREEN = 6;
`else
   localparam int PED_GREEN = 8;
`endif

   logic       clk = 1'b0;
   logic       reset, enable, ped_req;
   logic [7:0] red_time, green_time, yellow_time;
   logic [1:0] sw;
   logic [7:0] rem;
   logic       done, walk;

   int checks = 0;
   int errors = 0;

   // Model: phase id, loaded tick count, enabled cycles elapsed in the phase.
   int m_st, m_n, m_e;
   bit m_done, m_walk, m_pend, m_short;

   always #5 clk = ~clk;

   traffic_phase_scheduler #(.CNT_W(8), .PRESCALE(P), .MIN_GREEN(MING)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .red_time(red_time), .green_time(green_time), .yellow_time(yellow_time),
      .ped_req(ped_req), .sw_traffic_lights(sw), .phase_remaining(rem),
      .phase_done(done), .ped_walk(walk)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dur(input logic [7:0] t);
      return (t == 8'd0) ? 1 : int'(t);
   endfunction

   function automatic int m_rem();
      return (m_st == 0) ? 0 : m_n - m_e / P;
   endfunction

   task automatic model_enter(input int p);
      m_st = p; m_e = 0; m_done = 1; m_short = 0;
      case (p)
         1: m_n = dur(red_time);
         2: m_n = dur(green_time);
         default: m_n = dur(yellow_time);
      endcase
   endtask

   task automatic model_edge();
      bit req_ok, old_pend;
      int old_rem, nxt;
      if (reset) begin
         m_st = 0; m_n = 0; m_e = 0; m_done = 0; m_walk = 0; m_pend = 0; m_short = 0;
         return;
      end
      req_ok   = ped_req && !(m_st == 1 && m_walk);
      old_pend = m_pend;
      old_rem  = m_rem();
      if (!enable) begin
         m_done = 0;
         if (req_ok) m_pend = 1;
         return;
      end
      if (m_st == 0) begin
         model_enter(1);
         m_walk = old_pend | ped_req; m_pend = 0;
         return;
      end
      m_e++;
      m_done = 0;
      if (m_e == m_n * P) begin
         nxt = (m_st == 3) ? 1 : m_st + 1;
         model_enter(nxt);
         if (nxt == 1) begin
            m_walk = old_pend | ped_req; m_pend = 0;
         end else begin
            m_walk = 0;
            if (req_ok) m_pend = 1;
         end
      end else begin
         if (req_ok) m_pend = 1;
`ifdef TRAFFIC_PED_SHORTEN_EN
         if (m_st == 2 && old_pend && !m_short && old_rem > MING) begin
            m_n = MING + m_e / P;
            m_short = 1;
         end
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("sw", int'(sw), m_st);
      chk("phase_remaining", int'(rem), m_rem());
      chk("phase_done", int'(done), int'(m_done));
      chk("ped_walk", int'(walk), int'(m_walk));
   endtask

   // Counts sampled cycles spent in exp_sw, starting from 'start' already seen.
   task automatic measure(input string name, input int exp_sw, input int start, input int exp_len);
      int cnt, guard;
      cnt = start; guard = 0;
      while (int'(sw) == exp_sw && guard < 300) begin
         step();
         guard++;
         if (int'(sw) == exp_sw) cnt++;
      end
      chk(name, cnt, exp_len);
   endtask

   initial begin
      int exp_red[6];
      int wc;
      exp_red = '{3, 3, 2, 2, 1, 1};
      reset = 1'b1; enable = 1'b0; ped_req = 1'b0;
      red_time = 8'd3; green_time = 8'd4; yellow_time = 8'd2;
      repeat (3) step();
      chk("reset_sw", int'(sw), 0);
      chk("reset_rem", int'(rem), 0);
      chk("reset_walk", int'(walk), 0);

      // Nominal cycle
      reset = 1'b0; enable = 1'b1;
      step();
      chk("enter_red_sw", int'(sw), 1);
      chk("enter_red_done", int'(done), 1);
      for (int i = 0; i < 6; i++) begin
         chk("red_rem", int'(rem), exp_red[i]);
         step();
      end
      chk("green_sw", int'(sw), 2);
      chk("green_done", int'(done), 1);
      chk("green_rem", int'(rem), 4);
      measure("green_len", 2, 1, 8);
      chk("yellow_sw", int'(sw), 3);
      measure("yellow_len", 3, 1, 4);
      chk("red_again_sw", int'(sw), 1);

      // Zero-duration green
      green_time = 8'd0;
      measure("red_len", 1, 1, 6);
      measure("zero_green_len", 2, 1, 2);
      green_time = 8'd4;
      measure("yellow_len2", 3, 1, 4);

      // Enable freeze mid-green
      measure("red_len2", 1, 1, 6);
      step(); step();
      chk("freeze_pre_rem", int'(rem), 3);
      enable = 1'b0;
      repeat (5) begin
         step();
         chk("freeze_sw", int'(sw), 2);
         chk("freeze_rem", int'(rem), 3);
      end
      enable = 1'b1;
      measure("freeze_green_len", 2, 8, 13);

      // Pedestrian request and ignored repeat
      measure("yellow_len3", 3, 1, 4);
      chk("red_no_walk", int'(walk), 0);
      measure("red_len3", 1, 1, 6);
      ped_req = 1'b1; step(); ped_req = 1'b0;
      measure("ped_green_len", 2, 2, PED_GREEN);
      measure("yellow_len4", 3, 1, 4);
      wc = 0;
      for (int i = 0; i < 6; i++) begin
         if (walk) wc++;
         ped_req = (i == 2);
         step();
      end
      ped_req = 1'b0;
      chk("walk_cycles", wc, 6);
      chk("walk_clear", int'(walk), 0);
      measure("green_len2", 2, 1, 8);
      measure("yellow_len5", 3, 1, 4);
      chk("second_req_ignored", int'(walk), 0);

      // Reset mid-yellow discards a pending request
      measure("red_len4", 1, 1, 6);
      measure("green_len3", 2, 1, 8);
      step();
      ped_req = 1'b1; step(); ped_req = 1'b0;
      reset = 1'b1; step();
      chk("midreset_sw", int'(sw), 0);
      chk("midreset_rem", int'(rem), 0);
      chk("midreset_walk", int'(walk), 0);
      chk("midreset_done", int'(done), 0);
      reset = 1'b0; step();
      chk("restart_sw", int'(sw), 1);
      chk("restart_rem", int'(rem), 3);
      chk("restart_walk", int'(walk), 0);

      // Long green with an early request
      green_time = 8'd10;
      measure("red_len5", 1, 1, 6);
      chk("long_green_rem", int'(rem), 10);
      ped_req = 1'b1; step(); ped_req = 1'b0;
      step();
`ifdef TRAFFIC_PED_SHORTEN_EN
      chk("short_rem", int'(rem), 2);
      measure("short_green_len", 2, 3, 6);
`else
      chk("long_rem", int'(rem), 9);
      measure("long_green_len", 2, 3, 20);
`endif
      green_time = 8'd4;

      // Randomized traffic
      repeat (3000) begin
         reset   = ($urandom_range(0, 299) == 0);
         enable  = ($urandom_range(0, 9) != 0);
         ped_req = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 19) == 0) begin
            red_time    = 8'($urandom_range(0, 5));
            green_time  = 8'($urandom_range(0, 5));
            yellow_time = 8'($urandom_range(0, 5));
         end
         step();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
